serial_twos_comp_mc: RTL and testbench

//  Multi-channel, word-framed serial two's-complement unit.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_tc_lane.sv | 101 ++++++++++
 rtl/serial_twos_comp_mc.sv | 45 ++++
 tb/tb_serial_twos_comp_mc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : serial_pkg
// Brief   : Shared lane-state encoding and mode constants for the serial
//           two's-complement datapath.
// Revision: 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2
    } lane_state_t;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NEG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_tc_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : serial_tc_lane
// Brief   : One LSB-first serial lane: passes or negates a framed WIDTH-bit word
//           with one clock of latency, stall support and overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module serial_tc_lane
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic t_clk,
    input  logic r,
    input  logic i_vld,
    input  logic i_sow,
    input  logic i,
    input  logic neg,
    output logic y,
    output logic y_vld,
    output logic y_eow,
    output logic ovf
);

    localparam int             CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]  c_LAST_CNT = CW'(WIDTH - 1);

    lane_state_t   r_state, w_state_nxt, w_state_eff;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_eff;
    logic          r_neg_q, w_neg_nxt, w_neg_eff;
    logic          r_y, w_y_nxt;
    logic          r_y_vld, w_y_vld_nxt;
    logic          r_y_eow, w_y_eow_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          w_accept, w_last;

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_neg_q <= MODE_PASS;
            r_y     <= 1'b0;
            r_y_vld <= 1'b0;
            r_y_eow <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_neg_q <= w_neg_nxt;
            r_y     <= w_y_nxt;
            r_y_vld <= w_y_vld_nxt;
            r_y_eow <= w_y_eow_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // A start-of-word bit restarts the lane regardless of where the old word was.
    always_comb begin
        w_accept    = i_vld & (i_sow | (r_state != IDLE));
        w_neg_eff   = i_sow ? neg : r_neg_q;
        w_state_eff = i_sow ? COPY : r_state;
        w_cnt_eff   = i_sow ? '0 : r_cnt;
        w_last      = (w_cnt_eff == c_LAST_CNT);

        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_neg_nxt   = r_neg_q;
        w_y_nxt     = r_y;
        w_y_vld_nxt = 1'b0;
        w_y_eow_nxt = 1'b0;
        w_ovf_nxt   = 1'b0;

        if (w_accept) begin
            w_neg_nxt   = w_neg_eff;
            w_y_vld_nxt = 1'b1;
            w_y_nxt     = ((w_neg_eff == MODE_NEG) && (w_state_eff == INVERT)) ? ~i : i;
            if (w_last) begin
                w_y_eow_nxt = 1'b1;
                // Still copying at the MSB means every lower bit was zero.
                w_ovf_nxt   = (w_neg_eff == MODE_NEG) & i & (w_state_eff == COPY);
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = w_cnt_eff + CW'(1);
                if (w_neg_eff == MODE_NEG) begin
                    w_state_nxt = ((w_state_eff == COPY) && i) ? INVERT : w_state_eff;
                end else begin
                    w_state_nxt = COPY;
                end
            end
        end
    end

    assign y     = r_y;
    assign y_vld = r_y_vld;
    assign y_eow = r_y_eow;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/serial_twos_comp_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : serial_twos_comp_mc
// Brief   : CH independent word-framed serial two's-complement lanes.
// Revision: 1.0 - initial release
// ============================================================================
module serial_twos_comp_mc #(
    parameter int WIDTH = 8,
    parameter int CH    = 2
) (
    input  logic          t_clk,
    input  logic          r,
    input  logic [CH-1:0] i_vld,
    input  logic [CH-1:0] i_sow,
    input  logic [CH-1:0] i,
    input  logic [CH-1:0] neg,
    output logic [CH-1:0] y,
    output logic [CH-1:0] y_vld,
    output logic [CH-1:0] y_eow,
    output logic [CH-1:0] ovf
);

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_lane
            serial_tc_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .t_clk (t_clk),
                .r     (r),
                .i_vld (i_vld[g]),
                .i_sow (i_sow[g]),
                .i     (i[g]),
                .neg   (neg[g]),
                .y     (y[g]),
                .y_vld (y_vld[g]),
                .y_eow (y_eow[g]),
                .ovf   (ovf[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_comp_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_serial_twos_comp_mc
// Brief   : Vector table, directed corner sequences and randomized traffic
//           against an arithmetic reference model for serial_twos_comp_mc.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_twos_comp_mc;

    localparam int W  = 4;
    localparam int CH = 2;

    logic          t_clk;
    logic          r;
    logic [CH-1:0] i_vld, i_sow, i_bit, neg;
    logic [CH-1:0] y, y_vld, y_eow, ovf;

    int n_checks;
    int n_fail;

    // Reference model: the word received so far, negated arithmetically.
    bit          m_active [CH];
    int          m_idx    [CH];
    logic [31:0] m_acc    [CH];
    bit          m_neg    [CH];
    logic        e_y      [CH];
    logic        e_vld    [CH];
    logic        e_eow    [CH];
    logic        e_ovf    [CH];

    typedef struct {
        bit         ng;
        logic [3:0] word;
        logic [3:0] yexp;
        bit         ovf;
    } vec_t;

    vec_t tbl [8];

    serial_twos_comp_mc #(
        .WIDTH (W),
        .CH    (CH)
    ) u_dut (
        .t_clk (t_clk),
        .r     (r),
        .i_vld (i_vld),
        .i_sow (i_sow),
        .i     (i_bit),
        .neg   (neg),
        .y     (y),
        .y_vld (y_vld),
        .y_eow (y_eow),
        .ovf   (ovf)
    );

    initial t_clk = 1'b0;
    always #200 t_clk = ~t_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < CH; l++) begin
            m_active[l] = 1'b0;
            m_idx[l]    = 0;
            m_acc[l]    = '0;
            m_neg[l]    = 1'b0;
            e_y[l]      = 1'b0;
            e_vld[l]    = 1'b0;
            e_eow[l]    = 1'b0;
            e_ovf[l]    = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [31:0] val;
        for (int l = 0; l < CH; l++) begin
            e_vld[l] = 1'b0;
            e_eow[l] = 1'b0;
            e_ovf[l] = 1'b0;
            if (i_vld[l] && (i_sow[l] || m_active[l])) begin
                if (i_sow[l]) begin
                    m_active[l] = 1'b1;
                    m_idx[l]    = 0;
                    m_acc[l]    = '0;
                    m_neg[l]    = neg[l];
                end
                m_acc[l] = m_acc[l] | (32'(i_bit[l]) << m_idx[l]);
                val      = m_neg[l] ? (32'd0 - m_acc[l]) : m_acc[l];
                e_y[l]   = val[m_idx[l]];
                e_vld[l] = 1'b1;
                if (m_idx[l] == W - 1) begin
                    e_eow[l]    = 1'b1;
                    e_ovf[l]    = m_neg[l] && (m_acc[l] == (32'd1 << (W - 1)));
                    m_active[l] = 1'b0;
                end else begin
                    m_idx[l]++;
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge t_clk);
        #1;
        for (int l = 0; l < CH; l++) begin
            chk($sformatf("mdl_y_l%0d", l),   32'(y[l]),     32'(e_y[l]));
            chk($sformatf("mdl_vld_l%0d", l), 32'(y_vld[l]), 32'(e_vld[l]));
            chk($sformatf("mdl_eow_l%0d", l), 32'(y_eow[l]), 32'(e_eow[l]));
            chk($sformatf("mdl_ovf_l%0d", l), 32'(ovf[l]),   32'(e_ovf[l]));
        end
    endtask

    task automatic set_lane(input int l, input bit v, input bit s, input bit b, input bit n);
        i_vld[l] = v;
        i_sow[l] = s;
        i_bit[l] = b;
        neg[l]   = n;
    endtask

    initial begin
        logic [3:0] wd;
        logic [3:0] ye;
        logic [3:0] ye1;

        n_checks = 0;
        n_fail   = 0;
        r        = 1'b0;
        i_vld    = '0;
        i_sow    = '0;
        i_bit    = '0;
        neg      = '0;
        model_reset();

        tbl[0] = '{1'b1, 4'd3,  4'b1101, 1'b0};
        tbl[1] = '{1'b1, 4'd8,  4'b1000, 1'b1};
        tbl[2] = '{1'b1, 4'd0,  4'b0000, 1'b0};
        tbl[3] = '{1'b1, 4'd1,  4'b1111, 1'b0};
        tbl[4] = '{1'b1, 4'd15, 4'b0001, 1'b0};
        tbl[5] = '{1'b0, 4'd5,  4'b0101, 1'b0};
        tbl[6] = '{1'b0, 4'd8,  4'b1000, 1'b0};
        tbl[7] = '{1'b1, 4'd7,  4'b1001, 1'b0};

        #100;
        chk("rst_y",     32'(y),     32'd0);
        chk("rst_y_vld", 32'(y_vld), 32'd0);
        chk("rst_y_eow", 32'(y_eow), 32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        #210;
        r = 1'b1;

        // Back-to-back words on lane 0 from the vector table.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < W; k++) begin
                set_lane(0, 1'b1, k == 0, tbl[t].word[k], tbl[t].ng);
                cyc();
                chk($sformatf("tbl%0d_y_b%0d", t, k), 32'(y[0]),     32'(tbl[t].yexp[k]));
                chk($sformatf("tbl%0d_vld_b%0d", t, k), 32'(y_vld[0]), 32'd1);
                chk($sformatf("tbl%0d_eow_b%0d", t, k), 32'(y_eow[0]), 32'(k == W - 1));
                chk($sformatf("tbl%0d_ovf_b%0d", t, k), 32'(ovf[0]),
                    32'((k == W - 1) && tbl[t].ovf));
            end
        end

        // Word 6 negated with a two-clock stall after bit 1.
        wd = 4'b0110;
        ye = 4'b1010;
        for (int k = 0; k < W; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 2; s++) begin
                    set_lane(0, 1'b0, 1'b0, 1'b0, 1'b1);
                    cyc();
                    chk("stall_vld", 32'(y_vld[0]), 32'd0);
                    chk("stall_y",   32'(y[0]),     32'(ye[1]));
                    chk("stall_eow", 32'(y_eow[0]), 32'd0);
                end
            end
            set_lane(0, 1'b1, k == 0, wd[k], 1'b1);
            cyc();
            chk($sformatf("stall_word_y_b%0d", k), 32'(y[0]),     32'(ye[k]));
            chk($sformatf("stall_word_eow_b%0d", k), 32'(y_eow[0]), 32'(k == W - 1));
        end

        // Word 5 on both lanes: lane 0 negated, lane 1 passed through.
        wd  = 4'b0101;
        ye  = 4'b1011;
        ye1 = 4'b0101;
        for (int k = 0; k < W; k++) begin
            set_lane(0, 1'b1, k == 0, wd[k], 1'b1);
            set_lane(1, 1'b1, k == 0, wd[k], 1'b0);
            cyc();
            chk($sformatf("dual_l0_y_b%0d", k), 32'(y[0]), 32'(ye[k]));
            chk($sformatf("dual_l1_y_b%0d", k), 32'(y[1]), 32'(ye1[k]));
            chk($sformatf("dual_eow_b%0d", k), 32'(y_eow), (k == W - 1) ? 32'd3 : 32'd0);
        end

        // Reset pulse mid-word, then unframed bits must be ignored.
        for (int k = 0; k < 2; k++) begin
            set_lane(0, 1'b1, k == 0, 1'b1, 1'b1);
            set_lane(1, 1'b1, k == 0, 1'b1, 1'b0);
            cyc();
        end
        r = 1'b0;
        #5;
        chk("midrst_y",     32'(y),     32'd0);
        chk("midrst_y_vld", 32'(y_vld), 32'd0);
        chk("midrst_y_eow", 32'(y_eow), 32'd0);
        chk("midrst_ovf",   32'(ovf),   32'd0);
        model_reset();
        #5;
        r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 1'b1, 1'b0, 1'b1, 1'b1);
            set_lane(1, 1'b1, 1'b0, 1'b1, 1'b0);
            cyc();
            chk("nosow_y_vld", 32'(y_vld), 32'd0);
            chk("nosow_y_eow", 32'(y_eow), 32'd0);
        end

        // Randomized lane traffic checked against the model inside cyc().
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < CH; l++) begin
                set_lane(l, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
